fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the 10-bit CPU. Owns the PC and drives the instruction memory.
//  Holds the fetched word stable in an instruction register that feeds controlunit.
//  Consumes controlunit's fetch_cntrl and PC_en to resolve sequential, bge, bne, jump and halt.
//  Sequences one instruction at a time: FETCH -> WAIT -> EXEC.
// PARAMETERS
//  WIDTH         10  data/address/instruction width
//  RESET_PC      0   PC value loaded on reset
//  IMEM_TIMEOUT  15  max WAIT cycles before fault (counter width = clog2(IMEM_TIMEOUT+1))
// PORTS
//  clk            in   1      system clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  fetch_cntrl    in   2      from controlunit: 00 seq, 01 bge, 10 bne, 11 jump
//  PC_en          in   1      from controlunit: 0 = halt instruction
//  alu_result     in   WIDTH  ALU output (rs - rt for branches)
//  branch_target  in   WIDTH  branch/jump target address (from $la register)
//  imem_addr      out  WIDTH  instruction memory address (= pc)
//  imem_req       out  1      one-cycle read request
//  imem_rdata     in   WIDTH  instruction memory read data
//  imem_valid     in   1      imem_rdata valid this cycle
//  instruction    out  WIDTH  instruction register, to controlunit
//  instr_valid    out  1      high for the one EXEC cycle; qualifies reg/RAM writes
//  pc             out  WIDTH  current PC
//  branch_taken   out  1      one-cycle pulse at end of EXEC when PC redirected
//  halted         out  1      high in HALT
//  fault          out  1      sticky; set on imem timeout
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, instruction=0, state=FETCH, wait_cnt=0.
//   All outputs are 0 except imem_addr=RESET_PC.
//  FETCH (1 cycle): imem_req=1, imem_addr=pc -> WAIT. imem_valid in FETCH is ignored (stale).
//  WAIT: on imem_valid: instruction<=imem_rdata, wait_cnt<=0 -> EXEC.
//   Otherwise wait_cnt++.
//   If wait_cnt==IMEM_TIMEOUT with no valid: fault<=1 -> HALT.
//  EXEC (1 cycle): instr_valid=1. instruction is held stable; controlunit decodes combinationally.
//   At the clock edge ending EXEC:
//   - PC_en==0: pc unchanged -> HALT.
//   - PC_en==1: pc<=next_pc -> FETCH.
//  next_pc by fetch_cntrl:
//   00: pc+1
//   01 (bge): branch_target if alu_result[WIDTH-1]==0, else pc+1
//   10 (bne): branch_target if alu_result!=0, else pc+1
//   11 (jump): branch_target unconditionally
//  branch_taken=1 for one cycle (FETCH after EXEC) iff pc was loaded from branch_target.
//  pc+1 wraps modulo 2^WIDTH (1023 -> 0); no overflow flag.
//  HALT: absorbing. halted=1, imem_req=0, instr_valid=0. Only rst exits.
//  imem_valid outside WAIT is ignored.
//  Latency: 3 cycles/instruction minimum (valid on first WAIT cycle); +1 per extra WAIT cycle.
//  fetch_cntrl, PC_en and alu_result are sampled only at the edge ending EXEC.
//  Reset asserted mid-WAIT: any late imem_valid after reset release lands in FETCH and is dropped.
//  Branch target equal to pc (self-loop) is legal and refetches the same address.
// STRUCTURE
//  cpu_pkg (shared):
//   - WIDTH
//   - FC_SEQ=2'b00, FC_BGE=2'b01, FC_BNE=2'b10, FC_JUMP=2'b11
//   - state encodings S_FETCH, S_WAIT, S_EXEC, S_HALT
//  Sub-module next_pc_sel: combinational pc, fetch_cntrl, alu_result, branch_target -> next_pc, taken.
//  fetch_unit itself holds the FSM, pc, instruction register, wait_cnt and fault.
// TESTING
//  1. Reset; memory returns 0000110010 @0 with 1-cycle latency
//     -> imem_addr=0, instruction=0x032 in EXEC, pc=1 after 3 cycles.
//  2. EXEC with fetch_cntrl=01, alu_result=10'h005, branch_target=40 -> pc=40, branch_taken pulse.
//     Repeat with alu_result=10'h3FF -> pc=old+1.
//  3. fetch_cntrl=10, alu_result=0 -> pc+1; alu_result=1, branch_target=7 -> pc=7.
//     fetch_cntrl=11 -> pc=branch_target.
//  4. pc=1023 sequential -> pc=0. PC_en=0 in EXEC -> halted=1, pc frozen, no imem_req for 20 cycles.
//  5. imem_valid withheld 16 cycles -> fault=1, halted=1.
//     Assert rst mid-WAIT, then late imem_valid -> ignored; pc=0, fault=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit CPU: datapath width, fetch-control codes
// and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int WIDTH = 10;

  localparam logic [1:0] FC_SEQ  = 2'b00;
  localparam logic [1:0] FC_BGE  = 2'b01;
  localparam logic [1:0] FC_BNE  = 2'b10;
  localparam logic [1:0] FC_JUMP = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_WAIT  = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: sequential increment or redirect to the
// branch/jump target depending on the control code and the ALU result.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [WIDTH-1:0] pc_i,
  input  logic [1:0]       fetch_cntrl_i,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic [WIDTH-1:0] branch_target_i,
  output logic [WIDTH-1:0] next_pc_o,
  output logic             taken_o
);

  logic [WIDTH-1:0] pcPlusOne;

  // Natural wrap at 2^WIDTH is intended; there is no overflow reporting.
  assign pcPlusOne = pc_i + WIDTH'(1);

  // bge tests the sign of rs - rt, bne tests for a non-zero difference.
  always_comb begin
    taken_o = 1'b0;
    case (fetch_cntrl_i)
      FC_SEQ:  taken_o = 1'b0;
      FC_BGE:  taken_o = ~alu_result_i[WIDTH-1];
      FC_BNE:  taken_o = |alu_result_i;
      FC_JUMP: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
    next_pc_o = taken_o ? branch_target_i : pcPlusOne;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, sequences FETCH -> WAIT -> EXEC per
// instruction, holds the instruction register and flags imem timeouts.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int               IMEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       fetch_cntrl,
  input  logic             PC_en,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_req,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_valid,
  output logic [WIDTH-1:0] instruction,
  output logic             instr_valid,
  output logic [WIDTH-1:0] pc,
  output logic             branch_taken,
  output logic             halted,
  output logic             fault
);

  localparam int CNT_W = $clog2(IMEM_TIMEOUT + 1);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fault_q, fault_d;
  logic             taken_q, taken_d;

  logic [WIDTH-1:0] nextPc;
  logic             nextTaken;

  next_pc_sel u_next_pc_sel (
    .pc_i            (pc_q),
    .fetch_cntrl_i   (fetch_cntrl),
    .alu_result_i    (alu_result),
    .branch_target_i (branch_target),
    .next_pc_o       (nextPc),
    .taken_o         (nextTaken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      taken_q    <= taken_d;
    end
  end

  // imem_valid is only honoured in WAIT, so stale or late responses are dropped.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q;
    taken_d    = 1'b0;
    case (state_q)
      S_FETCH: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          instr_d    = imem_rdata;
          wait_cnt_d = '0;
          state_d    = S_EXEC;
        end else if (wait_cnt_q == CNT_W'(IMEM_TIMEOUT)) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (PC_en) begin
          pc_d    = nextPc;
          taken_d = nextTaken;
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // The request is masked while reset is held so every output except the address reads 0.
  assign imem_req     = (state_q == S_FETCH) & ~rst;
  assign imem_addr    = pc_q;
  assign instr_valid  = (state_q == S_EXEC);
  assign halted       = (state_q == S_HALT);
  assign instruction  = instr_q;
  assign pc           = pc_q;
  assign branch_taken = taken_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable instruction memory,
// an instruction-level expectation model checked every cycle, and literal pins.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic             clk;
  logic             rst;
  logic [1:0]       fetch_cntrl;
  logic             PC_en;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_req;
  logic [WIDTH-1:0] imem_rdata;
  logic             imem_valid;
  logic [WIDTH-1:0] instruction;
  logic             instr_valid;
  logic [WIDTH-1:0] pc;
  logic             branch_taken;
  logic             halted;
  logic             fault;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [WIDTH-1:0] mem [1024];
  logic             memEn;
  int               memLat;
  logic             forceValid;
  logic [WIDTH-1:0] forceData;
  logic             pending;
  int               pendCnt;
  logic [WIDTH-1:0] pendAddr;

  logic             checkOn;
  logic             eReq, eValid, eTaken, eHalted, eFault;
  logic [WIDTH-1:0] eAddr, eInstr, ePc;
  logic [WIDTH-1:0] mPc, mInstr;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_cntrl   (fetch_cntrl),
    .PC_en         (PC_en),
    .alu_result    (alu_result),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .branch_taken  (branch_taken),
    .halted        (halted),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Memory answers `memLat` cycles after seeing a request (0 = never answers).
  always @(negedge clk) begin
    if (rst || !memEn) begin
      pending    = 1'b0;
      imem_valid = forceValid;
      imem_rdata = forceData;
    end else begin
      imem_valid = 1'b0;
      if (pending) begin
        pendCnt--;
        if (pendCnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem[pendAddr];
          pending    = 1'b0;
        end
      end
      if (imem_req && memLat > 0) begin
        pending  = 1'b1;
        pendCnt  = memLat;
        pendAddr = imem_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("imem_req",     {9'b0, imem_req},     {9'b0, eReq});
      checkOutput("imem_addr",    imem_addr,            eAddr);
      checkOutput("instr_valid",  {9'b0, instr_valid},  {9'b0, eValid});
      checkOutput("instruction",  instruction,          eInstr);
      checkOutput("pc",           pc,                   ePc);
      checkOutput("branch_taken", {9'b0, branch_taken}, {9'b0, eTaken});
      checkOutput("halted",       {9'b0, halted},       {9'b0, eHalted});
      checkOutput("fault",        {9'b0, fault},        {9'b0, eFault});
    end
  end

  // Expectations for the FETCH cycle that follows a reset release.
  task automatic expectFetchAfterReset();
    mPc = '0; mInstr = '0;
    eReq = 1'b1; eAddr = '0; ePc = '0; eValid = 1'b0; eInstr = '0;
    eTaken = 1'b0; eHalted = 1'b0; eFault = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle to the next FETCH (or HALT).
  task automatic applyStimulus(input logic [1:0] cntrl, input logic en,
                               input logic [WIDTH-1:0] alu, input logic [WIDTH-1:0] tgt,
                               input int lat);
    bit               take;
    logic [WIDTH-1:0] nxt;
    fetch_cntrl = cntrl; PC_en = en; alu_result = alu; branch_target = tgt; memLat = lat;
    repeat (lat) begin
      stepCycle();
      eReq = 1'b0; eTaken = 1'b0;
    end
    stepCycle();
    mInstr = mem[mPc]; eInstr = mInstr; eValid = 1'b1;
    case (cntrl)
      FC_BGE:  take = ($signed(alu) >= 0);
      FC_BNE:  take = (alu != 0);
      FC_JUMP: take = 1'b1;
      default: take = 1'b0;
    endcase
    nxt = take ? tgt : WIDTH'((int'(mPc) + 1) % 1024);
    stepCycle();
    eValid = 1'b0;
    if (en) begin
      mPc = nxt; eReq = 1'b1; eAddr = nxt; ePc = nxt; eTaken = take;
    end else begin
      eHalted = 1'b1; eTaken = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; fetch_cntrl = FC_SEQ; PC_en = 1'b1; alu_result = '0; branch_target = '0;
    memEn = 1'b1; memLat = 1; forceValid = 1'b0; forceData = '0; checkOn = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = WIDTH'(i * 37 + 5);
    mem[0] = 10'h032;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_addr",    imem_addr,              10'd0);
    checkOutput("rst_req",     {9'b0, imem_req},       10'd0);
    checkOutput("rst_instr",   instruction,            10'd0);
    checkOutput("rst_halted",  {9'b0, halted},         10'd0);
    #1;
    rst = 1'b0;
    expectFetchAfterReset();
    checkOn = 1'b1;

    applyStimulus(FC_SEQ, 1'b1, 10'h000, 10'd0, 1);
    checkOutput("t1_pc",    pc,          10'd1);
    checkOutput("t1_instr", instruction, 10'h032);

    applyStimulus(FC_BGE, 1'b1, 10'h005, 10'd40, 1);
    checkOutput("t2_bge_pc",    pc,                    10'd40);
    checkOutput("t2_bge_taken", {9'b0, branch_taken},  10'd1);
    applyStimulus(FC_BGE, 1'b1, 10'h3FF, 10'd99, 2);
    checkOutput("t2_bge_neg_pc", pc, 10'd41);

    applyStimulus(FC_BNE, 1'b1, 10'h000, 10'd200, 1);
    checkOutput("t3_bne_zero_pc", pc, 10'd42);
    applyStimulus(FC_BNE, 1'b1, 10'h001, 10'd7, 1);
    checkOutput("t3_bne_pc", pc, 10'd7);
    applyStimulus(FC_JUMP, 1'b1, 10'h000, 10'd1023, 3);
    checkOutput("t3_jump_pc", pc, 10'd1023);

    applyStimulus(FC_SEQ, 1'b1, 10'h123, 10'd500, 1);
    checkOutput("t4_wrap_pc", pc, 10'd0);
    applyStimulus(FC_JUMP, 1'b1, 10'h000, 10'd0, 1);
    checkOutput("t4_selfloop_taken", {9'b0, branch_taken}, 10'd1);
    applyStimulus(FC_SEQ, 1'b1, 10'h000, 10'd0, 1);
    applyStimulus(FC_SEQ, 1'b0, 10'h000, 10'd0, 1);
    fetch_cntrl = FC_JUMP; branch_target = 10'd300; PC_en = 1'b1;
    repeat (20) stepCycle();
    checkOutput("t4_halt_pc",     pc,              10'd1);
    checkOutput("t4_halt_halted", {9'b0, halted},  10'd1);

    checkOn = 1'b0; rst = 1'b1; memLat = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    expectFetchAfterReset();
    checkOn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      stepCycle();
      eReq = 1'b0;
    end
    stepCycle();
    eHalted = 1'b1; eFault = 1'b1;
    repeat (3) stepCycle();
    checkOutput("t5_fault",  {9'b0, fault},  10'd1);
    checkOutput("t5_halted", {9'b0, halted}, 10'd1);

    checkOn = 1'b0; rst = 1'b1;
    #1;
    checkOutput("t5_async_fault_clr", {9'b0, fault},  10'd0);
    checkOutput("t5_async_halt_clr",  {9'b0, halted}, 10'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    expectFetchAfterReset();
    checkOn = 1'b1;
    stepCycle();
    eReq = 1'b0;
    stepCycle();
    #1;
    checkOn = 1'b0; rst = 1'b1; memEn = 1'b0; forceValid = 1'b1; forceData = 10'h155;
    @(posedge clk);
    #2;
    rst = 1'b0;
    expectFetchAfterReset();
    checkOn = 1'b1;
    stepCycle();
    forceValid = 1'b0;
    eReq = 1'b0;
    repeat (2) stepCycle();
    checkOutput("t5_late_pc",    pc,                   10'd0);
    checkOutput("t5_late_fault", {9'b0, fault},        10'd0);
    checkOutput("t5_late_instr", instruction,          10'd0);
    checkOutput("t5_late_valid", {9'b0, instr_valid},  10'd0);
    checkOn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
